// File: rtl/ps2_mouse_config_sequencer_if.sv
// Transmitter/receiver handshake between the mouse configuration sequencer
// (master) and the PS/2 byte-level PHY (slave).
interface ps2_mouse_config_sequencer_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/ps2_mouse_config_sequencer.sv
// PS/2 mouse configuration sequencer: reset, rate, resolution, enable reporting,
// then hand the receiver to the streaming path. Config/status on the CPU bus.
module ps2_mouse_config_sequencer #(
  parameter logic [7:0]  BASE_ADDR      = 8'hA4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd60_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [7:0]  DEFAULT_RATE   = 8'd100,
  parameter logic [7:0]  DEFAULT_RES    = 8'h02
) (
  input  logic                                CLK,
  input  logic                                RESET,
  inout  wire  [7:0]                          BUS_DATA,
  input  logic [7:0]                          BUS_ADDR,
  input  logic                                BUS_WE,
  ps2_mouse_config_sequencer_if.master        phy,
  output logic                                STREAM_EN,
  output logic                                CFG_BUSY,
  output logic                                CFG_ERROR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_WAIT_SENT, ST_WAIT_RX, ST_CHECK, ST_STREAM, ST_FAIL
  } state_t;

  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);

  state_t      r_state, w_next;
  logic [1:0]  r_grp, w_grp;
  logic        r_byte, w_byte;
  logic [1:0]  r_resp, w_resp;
  logic [7:0]  r_retry, w_retry;
  logic [31:0] r_timer;
  logic [7:0]  r_rx_byte;
  logic [1:0]  r_rx_err;
  logic        r_boot;
  logic [7:0]  r_rate, r_res, r_byte_to_send, r_rd_data;
  logic        r_rd_en;

  logic [7:0]  w_off;
  logic        w_hit, w_start, w_timeout, w_bad, w_fail, w_last_byte;
  logic [1:0]  w_last_resp;

  function automatic logic [7:0] f_cmd(input logic [1:0] g, input logic b,
                                       input logic [7:0] rate, input logic [7:0] res);
    case (g)
      2'd0:    return 8'hFF;
      2'd1:    return b ? rate : 8'hF3;
      2'd2:    return b ? res  : 8'hE8;
      default: return 8'hF4;
    endcase
  endfunction

  // Only the reset command has a multi-byte reply (ACK, self-test pass, ID).
  function automatic logic [7:0] f_exp(input logic [1:0] g, input logic [1:0] r);
    if (g == 2'd0) begin
      case (r)
        2'd0:    return 8'hFA;
        2'd1:    return 8'hAA;
        default: return 8'h00;
      endcase
    end
    return 8'hFA;
  endfunction

  assign w_off       = BUS_ADDR - BASE_ADDR;
  assign w_hit       = (w_off < 8'd3);
  assign w_start     = BUS_WE && w_hit && (w_off[1:0] == 2'd2) && BUS_DATA[0];
  assign w_timeout   = (r_timer == TIMEOUT_CYCLES - 32'd1);
  assign w_last_resp = (r_grp == 2'd0) ? 2'd2 : 2'd0;
  assign w_last_byte = (r_grp == 2'd1) || (r_grp == 2'd2);
  assign w_bad       = (r_rx_err != 2'd0) || (r_rx_byte == 8'hFE) ||
                       (r_rx_byte != f_exp(r_grp, r_resp));

  always_comb begin
    w_next  = r_state;
    w_grp   = r_grp;
    w_byte  = r_byte;
    w_resp  = r_resp;
    w_retry = r_retry;
    w_fail  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next  = ST_SEND;
        w_grp   = '0;
        w_byte  = 1'b0;
        w_resp  = '0;
        w_retry = '0;
      end
      ST_SEND:      w_next = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (phy.BYTE_SENT) w_next = ST_WAIT_RX;
        else if (w_timeout) w_fail = 1'b1;
      end
      ST_WAIT_RX: begin
        if (phy.BYTE_READY) w_next = ST_CHECK;
        else if (w_timeout) w_fail = 1'b1;
      end
      ST_CHECK: begin
        if (w_bad) begin
          w_fail = 1'b1;
        end else if (r_resp != w_last_resp) begin
          w_resp = r_resp + 2'd1;
          w_next = ST_WAIT_RX;
        end else if (r_byte != w_last_byte) begin
          w_byte = 1'b1;
          w_resp = '0;
          w_next = ST_SEND;
        end else if (r_grp != 2'd3) begin
          w_grp  = r_grp + 2'd1;
          w_byte = 1'b0;
          w_resp = '0;
          w_next = ST_SEND;
        end else begin
          w_next = ST_STREAM;
        end
      end
      ST_STREAM, ST_FAIL: if (w_start) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // A start arriving on the exhaustion cycle rescues the run instead of failing.
    if (w_fail) begin
      if (r_retry == RETRY_LIMIT) begin
        w_next = w_start ? ST_IDLE : ST_FAIL;
      end else begin
        w_retry = r_retry + 8'd1;
        w_byte  = 1'b0;
        w_resp  = '0;
        w_next  = ST_SEND;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= ST_IDLE;
      r_grp          <= '0;
      r_byte         <= 1'b0;
      r_resp         <= '0;
      r_retry        <= '0;
      r_timer        <= '0;
      r_rx_byte      <= '0;
      r_rx_err       <= '0;
      r_boot         <= 1'b1;
      r_byte_to_send <= '0;
    end else begin
      r_state <= w_next;
      r_grp   <= w_grp;
      r_byte  <= w_byte;
      r_resp  <= w_resp;
      r_retry <= w_retry;
      r_boot  <= 1'b0;
      if ((w_next != r_state) || !((r_state == ST_WAIT_SENT) || (r_state == ST_WAIT_RX)))
        r_timer <= '0;
      else
        r_timer <= r_timer + 32'd1;
      if ((r_state == ST_WAIT_RX) && phy.BYTE_READY) begin
        r_rx_byte <= phy.BYTE_READ;
        r_rx_err  <= phy.BYTE_ERROR_CODE;
      end
      if (w_next == ST_SEND)
        r_byte_to_send <= f_cmd(w_grp, w_byte, r_rate, r_res);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rate    <= DEFAULT_RATE;
      r_res     <= DEFAULT_RES;
      r_rd_en   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (BUS_WE && w_hit) begin
        case (w_off[1:0])
          2'd0:    r_rate <= BUS_DATA;
          2'd1:    r_res  <= BUS_DATA;
          default: ;
        endcase
      end
      r_rd_en <= w_hit && !BUS_WE;
      case (w_off[1:0])
        2'd0:    r_rd_data <= r_rate;
        2'd1:    r_rd_data <= r_res;
        default: r_rd_data <= {5'b0, CFG_ERROR, CFG_BUSY, STREAM_EN};
      endcase
    end
  end

  assign BUS_DATA         = r_rd_en ? r_rd_data : 8'hzz;
  assign phy.SEND_BYTE    = (r_state == ST_SEND);
  assign phy.BYTE_TO_SEND = r_byte_to_send;
  assign phy.READ_ENABLE  = (r_state == ST_WAIT_RX) || (r_state == ST_STREAM);
  assign STREAM_EN        = (r_state == ST_STREAM);
  assign CFG_ERROR        = (r_state == ST_FAIL);
  assign CFG_BUSY         = !((r_state == ST_STREAM) || (r_state == ST_FAIL) ||
                              ((r_state == ST_IDLE) && r_boot));

endmodule
